// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: byte-serial fetch, big-endian word assembly, prefetch FIFO.
// Ports: clk/rst, imem_en/imem_addr/imem_rdata, redirect_valid/redirect_pc,
//   instr_valid/instr_ready/instr/instr_pc/instr_next_pc, fifo_level.
module instr_fetch_unit #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] instr_next_pc,
  output logic [2:0]        fifo_level
);

  localparam int         PW   = $clog2(DEPTH);
  localparam logic [2:0] FULL = 3'(DEPTH);

  typedef enum logic [1:0] {
    BYTE0,
    BYTE1,
    BYTE2,
    BYTE3
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] fetch_pc;
  logic [23:0]       asm_q;
  logic [31:0]       mem_w  [DEPTH];
  logic [ADDR_W-1:0] mem_pc [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [2:0]        count;

  logic active, push, pop;

  // A new word only starts with a free slot, so push never overflows.
  assign active = (state != BYTE0) || (count < FULL);
  assign push   = active && (state == BYTE3);
  assign pop    = instr_valid && instr_ready;

  assign imem_en   = active && !rst;
  assign imem_addr = fetch_pc + ADDR_W'(state);

  assign instr_valid   = (count != 3'd0);
  assign instr         = instr_valid ? mem_w[rd_ptr] : 32'd0;
  assign instr_pc      = instr_valid ? mem_pc[rd_ptr] : '0;
  assign instr_next_pc = instr_valid ? mem_pc[rd_ptr] + ADDR_W'(4) : '0;
  assign fifo_level    = count;

  always_comb begin
    state_n = state;
    if (active) begin
      unique case (state)
        BYTE0: state_n = BYTE1;
        BYTE1: state_n = BYTE2;
        BYTE2: state_n = BYTE3;
        BYTE3: state_n = BYTE0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BYTE0;
      fetch_pc <= RESET_PC;
      asm_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      state    <= BYTE0;
      fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_n;
      if (active) begin
        unique case (state)
          BYTE0: asm_q[23:16] <= imem_rdata;
          BYTE1: asm_q[15:8]  <= imem_rdata;
          BYTE2: asm_q[7:0]   <= imem_rdata;
          BYTE3: fetch_pc     <= fetch_pc + ADDR_W'(4);
        endcase
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + 3'd1;
      else if (pop && !push) count <= count - 3'd1;
    end
  end

  // Storage needs no reset: the level counter alone qualifies entries.
  always_ff @(posedge clk) begin
    if (!rst && !redirect_valid && push) begin
      mem_w[wr_ptr]  <= {asm_q, imem_rdata};
      mem_pc[wr_ptr] <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed plan cases plus random traffic
// against a queue-based fetch model.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_en;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic [31:0] instr;
  logic [7:0] instr_pc;
  logic [7:0] instr_next_pc;
  logic [2:0] fifo_level;

  logic [7:0] imem [256];

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_w [$];
  logic [7:0]  m_p [$];
  logic [7:0]  m_pc = 8'h00;
  int          m_k  = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr];

  instr_fetch_unit #(
    .DEPTH(4),
    .ADDR_W(8),
    .RESET_PC(8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_en(imem_en),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_next_pc(instr_next_pc),
    .fifo_level(fifo_level)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [7:0] a);
    logic [7:0] b1, b2, b3;
    b1 = a + 8'd1;
    b2 = a + 8'd2;
    b3 = a + 8'd3;
    return {imem[a], imem[b1], imem[b2], imem[b3]};
  endfunction

  // One clock: drive, compare against model before the edge, advance model.
  task automatic cycle(input bit r, input bit rv, input logic [7:0] rp,
                       input bit rdy);
    bit act;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    instr_ready    = rdy;
    @(negedge clk);
    act = (m_k != 0) || (m_w.size() < 4);
    check("imem_en", 32'(imem_en), 32'(act && !r));
    check("imem_addr", 32'(imem_addr), 32'(8'(m_pc + 8'(m_k))));
    check("fifo_level", 32'(fifo_level), 32'(m_w.size()));
    check("instr_valid", 32'(instr_valid), 32'(m_w.size() != 0));
    if (m_w.size() != 0) begin
      check("instr", instr, m_w[0]);
      check("instr_pc", 32'(instr_pc), 32'(m_p[0]));
      check("instr_next_pc", 32'(instr_next_pc), 32'(8'(m_p[0] + 8'd4)));
    end else begin
      check("instr_empty", instr, 32'd0);
      check("pc_empty", 32'({instr_pc, instr_next_pc}), 32'd0);
    end
    @(posedge clk);
    if (r) begin
      m_w.delete();
      m_p.delete();
      m_pc = 8'h00;
      m_k  = 0;
    end else if (rv) begin
      m_w.delete();
      m_p.delete();
      m_pc = rp & 8'hFC;
      m_k  = 0;
    end else begin
      if (rdy && m_w.size() != 0) begin
        void'(m_w.pop_front());
        void'(m_p.pop_front());
      end
      if (act) begin
        if (m_k == 3) begin
          m_w.push_back(word_at(m_pc));
          m_p.push_back(m_pc);
          m_pc = m_pc + 8'd4;
          m_k  = 0;
        end else begin
          m_k++;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, rdy);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
    imem[0] = 8'h00; imem[1] = 8'h22; imem[2] = 8'h18; imem[3] = 8'h00;
    imem[8'hFC] = 8'h58; imem[8'hFD] = 8'h00;
    imem[8'hFE] = 8'h00; imem[8'hFF] = 8'h03;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    instr_ready = 1'b0;

    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("rst_en", 32'(imem_en), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'h00);

    idle(4, 1'b0);
    check("first_valid", 32'(instr_valid), 32'd1);
    check("first_instr", instr, 32'h00221800);
    check("first_pc", 32'(instr_pc), 32'h00);
    check("first_npc", 32'(instr_next_pc), 32'h04);
    check("first_lvl", 32'(fifo_level), 32'd1);

    idle(30, 1'b0);
    check("sat_lvl", 32'(fifo_level), 32'd4);
    check("sat_en", 32'(imem_en), 32'd0);
    check("sat_addr", 32'(imem_addr), 32'h10);
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 32'(instr_pc), 32'(i * 4));
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      if (i == 0) check("resume_addr", 32'(imem_addr), 32'h10);
    end

    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    idle(8, 1'b0);
    check("two_lvl", 32'(fifo_level), 32'd2);
    cycle(1'b0, 1'b1, 8'h2B, 1'b1);
    check("redir_lvl", 32'(fifo_level), 32'd0);
    check("redir_valid", 32'(instr_valid), 32'd0);
    check("redir_addr", 32'(imem_addr), 32'h28);
    idle(4, 1'b0);
    check("redir_pc", 32'(instr_pc), 32'h28);

    cycle(1'b0, 1'b1, 8'hFC, 1'b0);
    idle(4, 1'b0);
    check("wrap_instr", instr, 32'h58000003);
    check("wrap_pc", 32'(instr_pc), 32'hFC);
    check("wrap_npc", 32'(instr_next_pc), 32'h00);
    check("wrap_addr", 32'(imem_addr), 32'h00);

    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    idle(15, 1'b0);
    check("pp_lvl0", 32'(fifo_level), 32'd3);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    check("pp_lvl", 32'(fifo_level), 32'd3);
    check("pp_pc", 32'(instr_pc), 32'h04);

    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    idle(14, 1'b0);
    check("mid_lvl", 32'(fifo_level), 32'd3);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    check("mid_valid", 32'(instr_valid), 32'd0);
    check("mid_lvl0", 32'(fifo_level), 32'd0);
    check("mid_en", 32'(imem_en), 32'd0);
    check("mid_addr", 32'(imem_addr), 32'h00);
    check("mid_instr", instr, 32'd0);
    idle(4, 1'b0);
    check("mid_refetch", 32'(instr_pc), 32'h00);
    check("mid_refetch_v", 32'(instr_valid), 32'd1);

    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 99) < 4),
            8'($urandom),
            ($urandom_range(0, 99) < 45));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
